// File: rtl/vga_pkg.sv
// Shared constants and payload types for the VGA frame reader slice.
package vga_pkg;

   // 640x480@60 raster timing
   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Centred image geometry and RAM sizing
   localparam int unsigned IMG_W  = 320;
   localparam int unsigned IMG_H  = 240;
   localparam int unsigned X_OFF  = 160;
   localparam int unsigned Y_OFF  = 120;
   localparam int unsigned ADDR_W = 17;
   localparam int unsigned PIX_W  = 8;
   localparam int unsigned CNT_W  = 10;

   // Sync pulses are active low
   localparam logic SYNC_ACTIVE = 1'b0;

   // Control flags that travel alongside a pixel through the read pipeline
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
      logic rd;
   } pix_flags_t;

   localparam pix_flags_t FLAGS_RST = '{active: 1'b0, hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, rd: 1'b0};

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus VGA sink signals of the frame reader.
interface vga_frame_reader_if;
   import vga_pkg::*;

   logic              img_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [PIX_W-1:0]  mem_data;
   logic              vga_hs;
   logic              vga_vs;
   logic              vga_de;
   logic [PIX_W-1:0]  vga_r;
   logic [PIX_W-1:0]  vga_g;
   logic [PIX_W-1:0]  vga_b;
   logic              frame_start;

   modport master (
      input  img_valid, mem_data,
      output mem_addr, mem_rd_en, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start
   );

   modport slave (
      output img_valid, mem_data,
      input  mem_addr, mem_rd_en, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start
   );

endinterface

// File: rtl/vga_timing.sv
// Raster counters with sync, active-video, image-window and frame-start decode.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned H_ACT    = H_ACTIVE,
   parameter int unsigned H_FRONT  = H_FP,
   parameter int unsigned H_PULSE  = H_SYNC,
   parameter int unsigned H_BACK   = H_BP,
   parameter int unsigned V_ACT    = V_ACTIVE,
   parameter int unsigned V_FRONT  = V_FP,
   parameter int unsigned V_PULSE  = V_SYNC,
   parameter int unsigned V_BACK   = V_BP,
   parameter int unsigned IMG_COLS = IMG_W,
   parameter int unsigned IMG_ROWS = IMG_H,
   parameter int unsigned COL_OFF  = X_OFF,
   parameter int unsigned ROW_OFF  = Y_OFF
) (
   input  logic clk,
   input  logic reset,
   output logic active_c,
   output logic hs_c,
   output logic vs_c,
   output logic win_c,
   output logic origin_c,
   output logic frame_start
);

   localparam int unsigned H_TOT = H_ACT + H_FRONT + H_PULSE + H_BACK;
   localparam int unsigned V_TOT = V_ACT + V_FRONT + V_PULSE + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACT);
   localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACT);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACT + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACT + H_FRONT + H_PULSE);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACT + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACT + V_FRONT + V_PULSE);
   localparam logic [CNT_W-1:0] X_BEG  = CNT_W'(COL_OFF);
   localparam logic [CNT_W-1:0] X_END  = CNT_W'(COL_OFF + IMG_COLS);
   localparam logic [CNT_W-1:0] Y_BEG  = CNT_W'(ROW_OFF);
   localparam logic [CNT_W-1:0] Y_END  = CNT_W'(ROW_OFF + IMG_ROWS);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;

   // Horizontal counter wraps every line; vertical counter steps on each horizontal wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Position decode for the current counter value.
   always_comb begin
      active_c = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_c     = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_c     = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      win_c    = (h_cnt >= X_BEG) && (h_cnt < X_END) && (v_cnt >= Y_BEG) && (v_cnt < Y_END);
      origin_c = (h_cnt == '0) && (v_cnt == '0);
   end

   // Frame-start pulse, one cycle behind the origin position.
   always_ff @(posedge clk) begin
      if (reset) frame_start <= 1'b0;
      else       frame_start <= origin_c;
   end

endmodule

// File: rtl/vga_frame_reader.sv
// Streams the centred grayscale image from a 1-cycle-latency RAM to a VGA sink.
module vga_frame_reader
   import vga_pkg::*;
#(
   parameter int unsigned H_ACT    = H_ACTIVE,
   parameter int unsigned H_FRONT  = H_FP,
   parameter int unsigned H_PULSE  = H_SYNC,
   parameter int unsigned H_BACK   = H_BP,
   parameter int unsigned V_ACT    = V_ACTIVE,
   parameter int unsigned V_FRONT  = V_FP,
   parameter int unsigned V_PULSE  = V_SYNC,
   parameter int unsigned V_BACK   = V_BP,
   parameter int unsigned IMG_COLS = IMG_W,
   parameter int unsigned IMG_ROWS = IMG_H,
   parameter int unsigned COL_OFF  = X_OFF,
   parameter int unsigned ROW_OFF  = Y_OFF
) (
   input logic                 clk,
   input logic                 reset,
   vga_frame_reader_if.master  bus
);

   logic              active_c;
   logic              hs_c;
   logic              vs_c;
   logic              win_c;
   logic              origin_c;
   logic              rd_c;
   logic              show_img;
   logic [ADDR_W-1:0] addr_cnt;
   pix_flags_t        s1;
   pix_flags_t        s2;

   vga_timing #(
      .H_ACT    (H_ACT),
      .H_FRONT  (H_FRONT),
      .H_PULSE  (H_PULSE),
      .H_BACK   (H_BACK),
      .V_ACT    (V_ACT),
      .V_FRONT  (V_FRONT),
      .V_PULSE  (V_PULSE),
      .V_BACK   (V_BACK),
      .IMG_COLS (IMG_COLS),
      .IMG_ROWS (IMG_ROWS),
      .COL_OFF  (COL_OFF),
      .ROW_OFF  (ROW_OFF)
   ) u_timing (
      .clk         (clk),
      .reset       (reset),
      .active_c    (active_c),
      .hs_c        (hs_c),
      .vs_c        (vs_c),
      .win_c       (win_c),
      .origin_c    (origin_c),
      .frame_start (bus.frame_start)
   );

   // A read is due for every window pixel of a frame that was declared valid at its origin.
   assign rd_c = win_c & show_img;

   // Decide once per frame whether to show the image, so mid-frame changes wait a frame.
   always_ff @(posedge clk) begin
      if (reset)         show_img <= 1'b0;
      else if (origin_c) show_img <= bus.img_valid;
   end

   // Raster-order address: one increment per issued read, restarted at every frame origin.
   always_ff @(posedge clk) begin
      if (reset)         addr_cnt <= '0;
      else if (origin_c) addr_cnt <= '0;
      else if (rd_c)     addr_cnt <= addr_cnt + 1'b1;
   end

   // Stage 1: issue the RAM read and capture the position flags; address holds between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_rd_en <= 1'b0;
         bus.mem_addr  <= '0;
         s1            <= FLAGS_RST;
      end else begin
         bus.mem_rd_en <= rd_c;
         if (rd_c) bus.mem_addr <= addr_cnt;
         s1 <= '{active: active_c, hs: hs_c, vs: vs_c, rd: rd_c};
      end
   end

   // Stage 2: flags wait one cycle while the RAM produces the pixel.
   always_ff @(posedge clk) begin
      if (reset) s2 <= FLAGS_RST;
      else       s2 <= s1;
   end

   // Stage 3: register the sink outputs; grey goes to all three channels, everything else is black.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.vga_hs <= ~SYNC_ACTIVE;
         bus.vga_vs <= ~SYNC_ACTIVE;
         bus.vga_de <= 1'b0;
         bus.vga_r  <= '0;
         bus.vga_g  <= '0;
         bus.vga_b  <= '0;
      end else begin
         bus.vga_hs <= s2.hs;
         bus.vga_vs <= s2.vs;
         bus.vga_de <= s2.active;
         bus.vga_r  <= s2.rd ? bus.mem_data : '0;
         bus.vga_g  <= s2.rd ? bus.mem_data : '0;
         bus.vga_b  <= s2.rd ? bus.mem_data : '0;
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a shrunken-raster instance for full-frame readout and a
// full-size instance for the real 640x480 sync timing, both against a positional model.
`timescale 1ns/1ps
module tb_vga_frame_reader;

   // Shrunken raster so several whole frames fit in a short run
   localparam int S_HA = 16, S_HFP = 2, S_HSW = 3, S_HBP = 4;
   localparam int S_VA = 12, S_VFP = 1, S_VSW = 2, S_VBP = 2;
   localparam int S_IW = 8,  S_IH = 6,  S_XO = 4,  S_YO = 3;
   localparam int S_HT = S_HA + S_HFP + S_HSW + S_HBP;
   localparam int S_VT = S_VA + S_VFP + S_VSW + S_VBP;
   localparam int S_FT = S_HT * S_VT;

   // Real 640x480@60 raster
   localparam int D_HA = 640, D_HFP = 16, D_HSW = 96, D_HBP = 48;
   localparam int D_VA = 480, D_VFP = 10, D_VSW = 2,  D_VBP = 33;
   localparam int D_FT = (D_HA + D_HFP + D_HSW + D_HBP) * (D_VA + D_VFP + D_VSW + D_VBP);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic img_valid = 1'b0;

   always #20 clk = ~clk;

   vga_frame_reader_if sbus ();
   vga_frame_reader_if dbus ();

   assign sbus.img_valid = img_valid;
   assign dbus.img_valid = img_valid;
   assign dbus.mem_data  = 8'hA5;

   vga_frame_reader #(
      .H_ACT (S_HA), .H_FRONT (S_HFP), .H_PULSE (S_HSW), .H_BACK (S_HBP),
      .V_ACT (S_VA), .V_FRONT (S_VFP), .V_PULSE (S_VSW), .V_BACK (S_VBP),
      .IMG_COLS (S_IW), .IMG_ROWS (S_IH), .COL_OFF (S_XO), .ROW_OFF (S_YO)
   ) u_small (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus)
   );

   vga_frame_reader u_full (
      .clk   (clk),
      .reset (reset),
      .bus   (dbus)
   );

   // Synchronous RAM with one cycle of read latency
   logic [7:0] mem [64];
   always @(posedge clk) begin
      int ra;
      ra = int'(sbus.mem_addr);
      if (sbus.mem_rd_en) sbus.mem_data <= (ra < S_IW * S_IH) ? mem[6'(ra)] : 8'h00;
   end

   int          e;
   int          compared = 0;
   int          mismatched = 0;
   int          phase;
   int          rdcnt;
   int          d_first_fall;
   bit          show [16];
   logic [16:0] exp_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, e, obs, exp);
      end
   endtask

   // {hs, vs, de} for raster position q
   function automatic logic [2:0] sync_at(input int q, input int ha, input int hfp, input int hsw,
                                          input int hbp, input int va, input int vfp, input int vsw,
                                          input int vbp);
      int   ht = ha + hfp + hsw + hbp;
      int   vt = va + vfp + vsw + vbp;
      int   x  = q % ht;
      int   y  = (q / ht) % vt;
      logic hs = !((x >= ha + hfp) && (x < ha + hfp + hsw));
      logic vs = !((y >= va + vfp) && (y < va + vfp + vsw));
      logic de = (x < ha) && (y < va);
      return {hs, vs, de};
   endfunction

   // Image pixel index for raster position q of the small raster, if inside the window
   function automatic bit s_pixel(input int q, output int idx);
      int x = q % S_HT;
      int y = (q / S_HT) % S_VT;
      idx = (y - S_YO) * S_IW + (x - S_XO);
      return (x >= S_XO) && (x < S_XO + S_IW) && (y >= S_YO) && (y < S_YO + S_IH);
   endfunction

   // img_valid schedule: directed for the first frames, random toggles afterwards
   function automatic logic next_valid(input int t);
      int fr   = t / S_FT;
      int line = (t % S_FT) / S_HT;
      if (phase == 0 && fr == 0) return 1'b1;
      if (phase == 0 && fr == 1) return line < S_YO + 2;
      if (phase == 0 && fr == 2) return line >= S_YO + 2;
      if ($urandom_range(0, 99) == 0) return ~img_valid;
      return img_valid;
   endfunction

   task automatic check_reset_state();
      chk("rst_s_hs", sbus.vga_hs, 1);        chk("rst_d_hs", dbus.vga_hs, 1);
      chk("rst_s_vs", sbus.vga_vs, 1);        chk("rst_d_vs", dbus.vga_vs, 1);
      chk("rst_s_de", sbus.vga_de, 0);        chk("rst_d_de", dbus.vga_de, 0);
      chk("rst_s_rgb", {sbus.vga_r, sbus.vga_g, sbus.vga_b}, 0);
      chk("rst_d_rgb", {dbus.vga_r, dbus.vga_g, dbus.vga_b}, 0);
      chk("rst_s_addr", sbus.mem_addr, 0);    chk("rst_d_addr", dbus.mem_addr, 0);
      chk("rst_s_rd", sbus.mem_rd_en, 0);     chk("rst_d_rd", dbus.mem_rd_en, 0);
      chk("rst_s_fs", sbus.frame_start, 0);   chk("rst_d_fs", dbus.frame_start, 0);
   endtask

   task automatic check_cycle();
      int         q;
      int         idx;
      bit         hit;
      logic [2:0] sy;
      logic [2:0] dsy;
      logic [7:0] px;

      chk("s_frame_start", sbus.frame_start, ((e - 1) % S_FT) == 0);
      chk("d_frame_start", dbus.frame_start, ((e - 1) % D_FT) == 0);

      // read port lags the raster by one cycle
      q   = e - 1;
      hit = s_pixel(q, idx) && show[q / S_FT];
      if (hit) exp_addr = 17'(idx);
      chk("s_rd_en", sbus.mem_rd_en, hit);
      chk("s_addr", sbus.mem_addr, exp_addr);
      chk("d_rd_en", dbus.mem_rd_en, 0);
      chk("d_addr", dbus.mem_addr, 0);
      if (sbus.mem_rd_en === 1'b1) rdcnt++;
      if (e % S_FT == 0) begin
         chk("s_reads_per_frame", rdcnt, show[e / S_FT - 1] ? S_IW * S_IH : 0);
         rdcnt = 0;
      end

      // video outputs lag the raster by three cycles
      if (e < 3) begin
         sy  = 3'b110;
         dsy = 3'b110;
         px  = 8'h00;
      end else begin
         q   = e - 3;
         sy  = sync_at(q, S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP);
         dsy = sync_at(q, D_HA, D_HFP, D_HSW, D_HBP, D_VA, D_VFP, D_VSW, D_VBP);
         px  = (s_pixel(q, idx) && show[q / S_FT]) ? mem[6'(idx)] : 8'h00;
      end
      chk("s_hs", sbus.vga_hs, sy[2]);
      chk("s_vs", sbus.vga_vs, sy[1]);
      chk("s_de", sbus.vga_de, sy[0]);
      chk("s_r", sbus.vga_r, px);
      chk("s_g", sbus.vga_g, px);
      chk("s_b", sbus.vga_b, px);
      chk("d_hs", dbus.vga_hs, dsy[2]);
      chk("d_vs", dbus.vga_vs, dsy[1]);
      chk("d_de", dbus.vga_de, dsy[0]);
      chk("d_rgb", {dbus.vga_r, dbus.vga_g, dbus.vga_b}, 0);

      if (phase == 0 && d_first_fall < 0 && dbus.vga_hs === 1'b0) d_first_fall = e;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
         check_reset_state();
      end
      reset    = 1'b0;
      e        = 0;
      exp_addr = '0;
      rdcnt    = 0;
      foreach (show[i]) show[i] = 1'b0;
      img_valid = next_valid(0);
      show[0]   = img_valid;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         e++;
         check_cycle();
         img_valid = next_valid(e);
         if (e % S_FT == 0) show[e / S_FT] = img_valid;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      phase        = 0;
      d_first_fall = -1;
      img_valid    = 1'b1;
      do_reset(5);

      // shown frame, frame dropped mid-image, frame enabled too late, then random frames;
      // stop inside the image to pulse reset
      run(5 * S_FT + (S_YO + 1) * S_HT + 10);
      chk("d_first_hs_fall", d_first_fall, 3 + 656);

      phase = 1;
      do_reset(2);
      run(4 * S_FT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream stage of zoom_nn.
- Streams the 320x240 8-bit grayscale output frame from the synchronous output RAM to a 640x480@60 VGA sink.
- The image is centred with a black border, and grey is replicated on R, G and B.
- Generates all VGA timing and issues one RAM read per image pixel, with read addresses generated incrementally (no multiplier).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (frame total 525)
- IMG_W, 320, image width
- IMG_H, 240, image height
- X_OFF, 160, first image column
- Y_OFF, 120, first image line
- ADDR_W, 17, RAM address width (covers 76800 words)

Ports:
- clk  in  1  pixel clock (25 MHz)
- reset  in  1  synchronous, active-high
- img_valid  in  1  frame buffer holds a complete image; sampled only at frame start
- mem_addr  out  ADDR_W  RAM read address, equal to row*IMG_W+col
- mem_rd_en  out  1  read strobe
- mem_data  in  8  RAM read data; valid the cycle after mem_addr/mem_rd_en (1-cycle latency)
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  active-video enable
- vga_r  out  8  red channel
- vga_g  out  8  green channel
- vga_b  out  8  blue channel
- frame_start  out  1  one-cycle pulse when h=0 and v=0

Behaviour:
- Reset applies at a clock edge with reset=1:
  - h_cnt, v_cnt and addr_cnt go to 0; show_img goes to 0.
  - vga_hs=1, vga_vs=1, vga_de=0, rgb=0, mem_addr=0, mem_rd_en=0, frame_start=0.
  - All pipeline registers are cleared.
  - Reset mid-frame: outputs take their reset values on the next edge; the timing restarts at h=0, v=0 after reset is released.
- Stage 0 (counters):
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..524 and wraps to 0.
  - active = h<640 and v<480.
  - hs_n = 0 for h in [656,752).
  - vs_n = 0 for v in [490,492).
  - win = h in [X_OFF,X_OFF+IMG_W) and v in [Y_OFF,Y_OFF+IMG_H).
- show_img is loaded from img_valid only in the cycle where h=0 and v=0.
  - A change of img_valid mid-frame takes effect at the next frame start.
- Stage 1 (registered on the edge after stage 0):
  - mem_rd_en = win & show_img.
  - mem_addr = addr_cnt.
  - addr_cnt increments after each issued read.
  - addr_cnt is cleared at h=0, v=0 regardless of show_img.
  - In a complete shown frame, addresses run 0..76799 exactly once.
  - Outside reads, mem_addr holds its last value.
- Stage 2: mem_data is valid; the delayed active, hs_n, vs_n and rd flags travel alongside it.
- Stage 3 (output registers):
  - vga_hs, vga_vs and vga_de are the stage-2 delayed signals.
  - rgb = mem_data replicated to R, G and B when the delayed rd flag is 1, else 0.
  - Border pixels and blanking are black.
- Latency: every output lags its counter position by exactly 3 cycles.
  - frame_start is registered from the h=0, v=0 decode and is not delayed further (1-cycle lag).
- Sync keeps running while show_img=0: de is asserted normally, rgb=0, mem_rd_en=0.
- Counter comparisons use unsigned widths: h_cnt 10 bits, v_cnt 10 bits.

Decomposition:
- Package vga_pkg holds:
  - 640x480 timing constants and the derived H_TOTAL=800 and V_TOTAL=525.
  - IMG_W, IMG_H, X_OFF, Y_OFF and ADDR_W.
  - Sync polarity constant (active low).
- Sub-module vga_timing holds the h/v counters, sync decode, active/win decode and the frame-start pulse.
- vga_frame_reader instantiates vga_timing and adds the address counter, show_img latch and 3-stage pipeline.

Test Plan:
- Reset: hold reset 5 cycles, then release. Check:
  - All outputs are at reset values during reset.
  - First frame_start occurs 1 cycle after release.
  - vga_hs first falls 3+656 cycles after counting begins.
  - vga_hs stays low for 96 cycles; period 800 cycles.
- Frame timing with img_valid=0. Check:
  - vga_vs is low for 1600 cycles (2 lines) per frame.
  - Frame period is 420000 cycles.
  - vga_de is high 640 cycles per line on 480 lines.
  - rgb stays 0 and mem_rd_en is never asserted.
- Image readout: RAM model with 1-cycle latency holding mem[i]=i[7:0], img_valid=1 from the start. Check:
  - The first read is mem_addr=0 at line 120, column 160.
  - That line reads 0..319.
  - The last read is 76799 at line 359, column 479.
  - vga_r at line 120, column 160 is 0x00; at column 161 it is 0x01.
  - Column 159 and column 480 are 0.
- Exactly 76800 reads occur per frame; addr_cnt restarts at 0 on the next frame.
- img_valid asserted at line 200 of a frame:
  - That frame stays all black with no reads.
  - The next frame is shown in full.
- img_valid drops mid-frame:
  - The current frame completes all 76800 reads.
  - The following frame is black.
- Reset pulse at line 150, column 300:
  - On the next edge, outputs are at reset values and reads stop.
  - After release, timing restarts from h=0, v=0 with mem_addr=0 and frame_start=1.
